// File: rtl/sap1_loader.sv
// rtl/sap1_loader.sv - SAP-1 program loader and clear/run/halt sequencer
//
// Loads a byte stream (s_valid/s_ready/s_data/s_last) into the 2^ADDR_W byte
// program memory through the front-panel port, holds the core in clear for
// CLEAR_CYCLES clken pulses, releases it to run and reports halt.
//
// Ports:
//   sysclk, reset_n        clock, asynchronous active-low reset
//   clken, clken_oop       core step enable / memory-phase enable
//   start, rerun           level-sampled load and rerun requests
//   s_valid/s_data/s_last  program byte stream, s_ready back-pressure
//   halt                   HLT decoded by the core
//   fp_prog/fp_write/fp_adr/fp_data  front-panel memory write port
//   fp_clear, run          core clear and run release
//   busy, done             sequencer status
module sap1_loader #(
  parameter int ADDR_W       = 4,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic              clken,
  input  logic              clken_oop,
  input  logic              start,
  input  logic              rerun,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              halt,
  output logic              fp_prog,
  output logic              fp_write,
  output logic [ADDR_W-1:0] fp_adr,
  output logic [7:0]        fp_data,
  output logic              fp_clear,
  output logic              run,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_WAIT  = 3'd1,
    LOAD_WRITE = 3'd2,
    CLEAR      = 3'd3,
    RUN        = 3'd4,
    HALTED     = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [3:0]        CLR_LIMIT = 4'(CLEAR_CYCLES);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                last_q, last_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                fp_clear_q, fp_prog_q, fp_write_q, run_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_WAIT;
          addr_d  = '0;
        end else if (rerun) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      LOAD_WAIT: begin
        // s_ready is 1 throughout this state, so s_valid alone completes the handshake
        if (s_valid) begin
          data_d  = s_data;
          last_d  = s_last;
          state_d = LOAD_WRITE;
        end
      end
      LOAD_WRITE: begin
        if (clken_oop) begin
          // The address counter saturates: the top location ends the load.
          if (last_q || (addr_q == ADDR_MAX)) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end else begin
            state_d = LOAD_WAIT;
            addr_d  = addr_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        if (clken) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == CLR_LIMIT) state_d = RUN;
        end
      end
      RUN: begin
        if (start) begin
          state_d = LOAD_WAIT;
          addr_d  = '0;
        end else if (halt) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (start) begin
          state_d = LOAD_WAIT;
          addr_d  = '0;
        end else if (rerun) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track the state
  // register exactly while still coming straight out of flops.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      fp_clear_q <= 1'b1;
      fp_prog_q  <= 1'b0;
      fp_write_q <= 1'b0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      fp_clear_q <= !((state_d == RUN) || (state_d == HALTED));
      fp_prog_q  <= (state_d == LOAD_WAIT) || (state_d == LOAD_WRITE);
      fp_write_q <= (state_d == LOAD_WRITE);
      run_q      <= (state_d == RUN);
      busy_q     <= (state_d == LOAD_WAIT) || (state_d == LOAD_WRITE) || (state_d == CLEAR);
      done_q     <= (state_d == HALTED);
    end
  end

  assign s_ready  = (state_q == LOAD_WAIT);
  assign fp_adr   = addr_q;
  assign fp_data  = data_q;
  assign fp_clear = fp_clear_q;
  assign fp_prog  = fp_prog_q;
  assign fp_write = fp_write_q;
  assign run      = run_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
